// File: rtl/unified_mem_arbiter.sv
// Two-requester arbiter (IF fetch, MEM access) in front of a single-port synchronous RAM.
// MEM wins conflicts, but after MAX_MEM_RUN consecutive wins IF is forced through.
module unified_mem_arbiter #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MAX_MEM_RUN = 4
) (
  input  logic              SYS_clk,
  input  logic              SYS_reset,
  // Instruction-fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  // Memory-access port
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_gnt,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_rdata,
  // RAM side
  output logic [31:0]       ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  // Status
  output logic              stall_if,
  output logic [15:0]       conflict_cnt
);

  localparam int unsigned RunW = $clog2(MAX_MEM_RUN + 1);

  typedef enum logic [1:0] {StNone, StIf, StMem} owner_e;

  logic [RunW-1:0] run_cnt_q, run_cnt_d;
  owner_e          rd_owner_q, rd_owner_d;
  logic [15:0]     conflict_q, conflict_d;
  logic            both_req;
  logic            run_full;

  // Grant decision; everything is held off while in reset.
  always_comb begin
    both_req = if_req & mem_req;
    run_full = (run_cnt_q == RunW'(MAX_MEM_RUN));
    mem_gnt  = 1'b0;
    if_gnt   = 1'b0;
    if (SYS_reset) begin
      if (mem_req && !(if_req && run_full)) begin
        mem_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_wren  = 1'b0;
    if (mem_gnt) begin
      ram_addr = 32'(mem_addr);
      if (mem_we) begin
        ram_wren  = 1'b1;
        ram_wdata = mem_wdata;
      end
    end else if (if_gnt) begin
      ram_addr = 32'(if_addr);
    end
  end

  always_comb begin
    run_cnt_d = run_cnt_q;
    if (both_req && mem_gnt) begin
      run_cnt_d = run_cnt_q + RunW'(1);
    end else if (if_gnt || !if_req) begin
      run_cnt_d = '0;
    end

    rd_owner_d = StNone;
    if (if_gnt) begin
      rd_owner_d = StIf;
    end else if (mem_gnt && !mem_we) begin
      rd_owner_d = StMem;
    end

    conflict_d = conflict_q;
    if (both_req && (conflict_q != 16'hFFFF)) begin
      conflict_d = conflict_q + 16'd1;
    end
  end

  always_ff @(posedge SYS_clk) begin
    if (!SYS_reset) begin
      run_cnt_q  <= '0;
      rd_owner_q <= StNone;
      conflict_q <= '0;
    end else begin
      run_cnt_q  <= run_cnt_d;
      rd_owner_q <= rd_owner_d;
      conflict_q <= conflict_d;
    end
  end

  // Read data is steered to whichever port owned last cycle's read grant.
  always_comb begin
    if_valid     = (rd_owner_q == StIf);
    mem_valid    = (rd_owner_q == StMem);
    if_rdata     = if_valid  ? ram_q : '0;
    mem_rdata    = mem_valid ? ram_q : '0;
    stall_if     = if_req & ~if_gnt;
    conflict_cnt = conflict_q;
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with a behavioural 1-cycle-latency RAM.
module tb_unified_mem_arbiter;

  logic        SYS_clk = 1'b0;
  logic        SYS_reset;
  logic        if_req;
  logic [7:0]  if_addr;
  logic        if_gnt, if_valid;
  logic [31:0] if_rdata;
  logic        mem_req, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt, mem_valid;
  logic [31:0] mem_rdata;
  logic [31:0] ram_addr, ram_wdata;
  logic        ram_wren;
  logic [31:0] ram_q;
  logic        stall_if;
  logic [15:0] conflict_cnt;

  logic [31:0] ram [256];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 SYS_clk = ~SYS_clk;

  unified_mem_arbiter #(
    .ADDR_W      (8),
    .DATA_W      (32),
    .MAX_MEM_RUN (4)
  ) dut (
    .SYS_clk      (SYS_clk),
    .SYS_reset    (SYS_reset),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_gnt       (if_gnt),
    .if_valid     (if_valid),
    .if_rdata     (if_rdata),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_gnt      (mem_gnt),
    .mem_valid    (mem_valid),
    .mem_rdata    (mem_rdata),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_wren     (ram_wren),
    .ram_q        (ram_q),
    .stall_if     (stall_if),
    .conflict_cnt (conflict_cnt)
  );

  always @(posedge SYS_clk) begin
    if (ram_wren) ram[ram_addr[7:0]] <= ram_wdata;
    ram_q <= ram[ram_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    bit exp_if [12];
    for (int i = 0; i < 256; i++) ram[i] = 32'(i + 100);
    for (int k = 0; k < 12; k++) exp_if[k] = (k == 4) || (k == 9);

    SYS_reset = 1'b0;
    if_req    = 1'b1;
    if_addr   = 8'h05;
    mem_req   = 1'b1;
    mem_we    = 1'b0;
    mem_addr  = 8'h20;
    mem_wdata = 32'h0;

    // Reset held with both requests high
    for (int k = 0; k < 3; k++) begin
      @(negedge SYS_clk); #1;
      chk("rst_if_gnt", 32'(if_gnt), 32'd0);
      chk("rst_mem_gnt", 32'(mem_gnt), 32'd0);
      chk("rst_wren", 32'(ram_wren), 32'd0);
      chk("rst_addr", ram_addr, 32'd0);
      chk("rst_stall", 32'(stall_if), 32'd1);
    end

    // Release reset and run the starvation pattern MMMMI MMMMI MM
    for (int k = 0; k < 12; k++) begin
      @(negedge SYS_clk);
      SYS_reset = 1'b1;
      #1;
      chk("st_conflict", 32'(conflict_cnt), 32'(k));
      chk("st_if_gnt", 32'(if_gnt), 32'(exp_if[k]));
      chk("st_mem_gnt", 32'(mem_gnt), 32'(!exp_if[k]));
      chk("st_stall", 32'(stall_if), 32'(!exp_if[k]));
      chk("st_addr", ram_addr, exp_if[k] ? 32'h05 : 32'h20);
      if (k == 0) begin
        chk("st_if_valid0", 32'(if_valid), 32'd0);
        chk("st_mem_valid0", 32'(mem_valid), 32'd0);
      end else begin
        chk("st_if_valid", 32'(if_valid), 32'(exp_if[k-1]));
        chk("st_mem_valid", 32'(mem_valid), 32'(!exp_if[k-1]));
        chk("st_if_rdata", if_rdata, exp_if[k-1] ? 32'd105 : 32'd0);
        chk("st_mem_rdata", mem_rdata, exp_if[k-1] ? 32'd0 : 32'd132);
      end
    end

    // IF only, addresses 0,1,2
    for (int k = 0; k < 3; k++) begin
      @(negedge SYS_clk);
      mem_req = 1'b0;
      if_req  = 1'b1;
      if_addr = 8'(k);
      #1;
      if (k == 0) begin
        chk("st_conflict_end", 32'(conflict_cnt), 32'd12);
        chk("st_mem_rdata_last", mem_rdata, 32'd132);
        chk("ifo_valid0", 32'(if_valid), 32'd0);
      end else begin
        chk("ifo_valid", 32'(if_valid), 32'd1);
        chk("ifo_rdata", if_rdata, 32'(99 + k));
      end
      chk("ifo_gnt", 32'(if_gnt), 32'd1);
      chk("ifo_stall", 32'(stall_if), 32'd0);
      chk("ifo_addr", ram_addr, 32'(k));
    end

    // MEM write DEADBEEF to 0x10
    @(negedge SYS_clk);
    if_req    = 1'b0;
    mem_req   = 1'b1;
    mem_we    = 1'b1;
    mem_addr  = 8'h10;
    mem_wdata = 32'hDEADBEEF;
    #1;
    chk("ifo_rdata_last", if_rdata, 32'd102);
    chk("wr_gnt", 32'(mem_gnt), 32'd1);
    chk("wr_wren", 32'(ram_wren), 32'd1);
    chk("wr_addr", ram_addr, 32'h10);
    chk("wr_wdata", ram_wdata, 32'hDEADBEEF);

    // MEM read back 0x10
    @(negedge SYS_clk);
    mem_we = 1'b0;
    #1;
    chk("rd_gnt", 32'(mem_gnt), 32'd1);
    chk("rd_wren", 32'(ram_wren), 32'd0);
    chk("rd_wdata", ram_wdata, 32'd0);
    chk("wr_no_valid", 32'(mem_valid), 32'd0);
    chk("wr_no_if_valid", 32'(if_valid), 32'd0);

    @(negedge SYS_clk);
    mem_req = 1'b0;
    #1;
    chk("idle_addr", ram_addr, 32'd0);
    chk("idle_wren", 32'(ram_wren), 32'd0);
    chk("rd_valid", 32'(mem_valid), 32'd1);
    chk("rd_rdata", mem_rdata, 32'hDEADBEEF);

    @(negedge SYS_clk); #1;
    chk("rd_valid_off", 32'(mem_valid), 32'd0);
    chk("rd_rdata_off", mem_rdata, 32'd0);

    // Reset while an IF read is in flight
    @(negedge SYS_clk);
    if_req  = 1'b1;
    if_addr = 8'h03;
    #1;
    chk("mr_gnt", 32'(if_gnt), 32'd1);

    @(negedge SYS_clk);
    SYS_reset = 1'b0;
    #1;
    chk("mr_rst_gnt", 32'(if_gnt), 32'd0);
    chk("mr_rst_stall", 32'(stall_if), 32'd1);

    @(negedge SYS_clk);
    SYS_reset = 1'b1;
    if_req    = 1'b0;
    #1;
    chk("mr_if_valid", 32'(if_valid), 32'd0);
    chk("mr_if_rdata", if_rdata, 32'd0);
    chk("mr_conflict", 32'(conflict_cnt), 32'd0);

    @(negedge SYS_clk); #1;
    chk("mr_owner_none", 32'(if_valid | mem_valid), 32'd0);

    // Saturation of the conflict counter
    @(negedge SYS_clk);
    if_req  = 1'b1;
    mem_req = 1'b1;
    repeat (65534) @(posedge SYS_clk);
    @(negedge SYS_clk); #1;
    chk("sat_fffe", 32'(conflict_cnt), 32'h0000FFFE);
    repeat (4466) @(posedge SYS_clk);
    @(negedge SYS_clk); #1;
    chk("sat_ffff", 32'(conflict_cnt), 32'h0000FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port synchronous RAM, with 1-cycle read latency, between two requesters: the instruction-fetch stage (IF port) and the memory-access stage (MEM port).
- Grants one requester per cycle and drives the RAM address, data and write-enable.
- Returns read data one cycle later with a valid strobe, and raises a fetch-stall signal toward the PC/IF-ID logic.
- MEM has priority, because it serves the older instruction. A bounded-run rule prevents IF starvation.

Parameters:
- ADDR_W, 8, requester address width; the RAM address is zero-extended to 32 bits.
- DATA_W, 32, data width.
- MAX_MEM_RUN, 4, max consecutive MEM-over-IF conflict wins before IF is forced a grant.

Ports:
- SYS_clk  in  1  system clock, rising edge
- SYS_reset  in  1  synchronous active-low reset (0 = reset, 1 = run)
- if_req  in  1  IF read request; held with if_addr until granted
- if_addr  in  ADDR_W  IF read address
- if_gnt  out  1  IF request accepted this cycle
- if_valid  out  1  IF read data valid (cycle after grant)
- if_rdata  out  DATA_W  IF read data; 0 when if_valid=0
- mem_req  in  1  MEM request; held with mem_we/addr/wdata until granted
- mem_we  in  1  1 = write, 0 = read
- mem_addr  in  ADDR_W  MEM address
- mem_wdata  in  DATA_W  MEM write data
- mem_gnt  out  1  MEM request accepted this cycle
- mem_valid  out  1  MEM read data valid (reads only)
- mem_rdata  out  DATA_W  MEM read data; 0 when mem_valid=0
- ram_addr  out  32  {zeros, granted address}; 0 when idle
- ram_wdata  out  DATA_W  mem_wdata when a MEM write is granted, else 0
- ram_wren  out  1  1 only in a cycle granting a MEM write
- ram_q  in  DATA_W  RAM registered read data
- stall_if  out  1  if_req & ~if_gnt (combinational)
- conflict_cnt  out  16  saturating count of cycles with both requests high

Behaviour:
- Reset is synchronous: on a rising SYS_clk edge with SYS_reset=0, all of the following are cleared.
  - run_cnt=0, rd_owner=NONE, conflict_cnt=0.
  - While SYS_reset=0: if_gnt=mem_gnt=0, ram_wren=0, ram_addr=0, ram_wdata=0, and stall_if=if_req.
  - if_valid, mem_valid, if_rdata and mem_rdata are 0 in the cycle after a reset edge, even if a read was in flight.
- Grant (combinational from current requests and run_cnt):
  - Only mem_req: MEM granted.
  - Only if_req: IF granted.
  - Both requests, run_cnt < MAX_MEM_RUN: MEM granted.
  - Both requests, run_cnt == MAX_MEM_RUN: IF granted.
  - Neither request: no grant, RAM idle.
- run_cnt register:
  - Increments on a cycle where both requests are high and MEM is granted.
  - Clears to 0 on any IF grant, or any cycle with if_req=0.
  - Otherwise holds. Range is 0..MAX_MEM_RUN.
- rd_owner register, a 3-state FSM {NONE, IF, MEM}:
  - Next state is IF on an IF grant, MEM on a MEM read grant, NONE otherwise (including MEM write grants).
- Read latency is exactly 1 cycle.
  - In cycle t+1 after a grant at t: if_valid=(rd_owner==IF) and if_rdata=ram_q; mem_valid=(rd_owner==MEM) and mem_rdata=ram_q.
  - Back-to-back grants are allowed every cycle. Throughput is 1 access/cycle.
- Writes:
  - Complete in the grant cycle: ram_wren=1, ram_addr=mem_addr, ram_wdata=mem_wdata.
  - No valid strobe is produced for a write.
- conflict_cnt increments on each run cycle with if_req & mem_req. It saturates at 16'hFFFF.
- Requesters must hold their request until granted. A request dropped before its grant is simply not served. No queuing.
- A write followed by a read to the same address on the next cycle returns the new data; no bypass is required.

Test Plan:
- Reset hold: SYS_reset=0 for 3 cycles with both reqs high -> gnts=0, ram_wren=0, stall_if=1, conflict_cnt=0; then SYS_reset=1 -> MEM granted first cycle.
- IF only: if_req=1, if_addr 0,1,2 on consecutive cycles with RAM preloaded mem[i]=i+100 -> if_gnt every cycle; if_valid from the next cycle with if_rdata 100,101,102; stall_if=0.
- MEM write then read: write 32'hDEADBEEF to addr 8'h10, then read 8'h10 -> ram_wren=1 for one cycle only; mem_valid one cycle after the read grant with mem_rdata=32'hDEADBEEF.
- Starvation bound: if_req and mem_req (reads) high for 12 cycles, MAX_MEM_RUN=4 -> grant pattern MMMMI MMMMI MM; stall_if=1 on exactly the 10 M cycles; conflict_cnt=12.
- Reset mid-read: IF grant at cycle t, SYS_reset=0 at t+1 edge -> if_valid=0 and if_rdata=0 after reset; rd_owner returns to NONE.
- Saturation: force 70000 conflict cycles -> conflict_cnt stays at 16'hFFFF.
